// File: rtl/alu_stream_ctrl.sv
// Streaming command front-end around a WIDTH-bit ALU.
// Single-op and eight-code sweep modes, registered results.
module alu_stream_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sweep,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_t,
  output logic [2:0]       out_f,
  output logic             out_last,
  output logic [CNT_W-1:0] res_cnt
);

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_OUT
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f_q;
  logic             sweep_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_y_q;
  logic [2:0]       out_t_q;
  logic [2:0]       out_f_q;
  logic             out_last_q;
  logic [CNT_W-1:0] res_cnt_q;

  logic [CNT_W-1:0] res_cnt_d;
  logic [2:0]       f_d;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_y;
  logic [2:0]       alu_t;

  assign res_cnt_d = res_cnt_q + 1'b1;
  assign f_d       = f_q + 3'd1;
  assign shamt     = b_q[SH_W-1:0];

  // Combinational ALU fed only from the operand registers.
  always_comb begin
    alu_y = '0;
    case (f_q)
      3'b000:  alu_y = a_q - b_q;
      3'b001:  alu_y = a_q + b_q;
      3'b010:  alu_y = a_q & b_q;
      3'b011:  alu_y = a_q | b_q;
      3'b100:  alu_y = a_q ^ b_q;
      3'b101:  alu_y = a_q >> shamt;
      3'b110:  alu_y = a_q << shamt;
      default: alu_y = $unsigned($signed(a_q) >>> shamt);
    endcase
  end

  // Compare flags: unsigned less, signed less, equal.
  always_comb begin
    alu_t    = '0;
    alu_t[2] = a_q < b_q;
    alu_t[1] = $signed(a_q) < $signed(b_q);
    alu_t[0] = a_q == b_q;
  end

  // Command FSM; every output comes straight from a register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      sweep_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_t_q     <= '0;
      out_f_q     <= '0;
      out_last_q  <= 1'b0;
      res_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            sweep_q <= in_sweep;
            f_q     <= in_sweep ? 3'b000 : in_f;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          out_y_q     <= alu_y;
          out_t_q     <= alu_t;
          out_f_q     <= f_q;
          out_valid_q <= 1'b1;
          out_last_q  <= !sweep_q || (f_q == 3'b111);
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            res_cnt_q   <= res_cnt_d;
            if (sweep_q && (f_q != 3'b111)) begin
              f_q     <= f_d;
              state_q <= S_EXEC;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_t     = out_t_q;
  assign out_f     = out_f_q;
  assign out_last  = out_last_q;
  assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_alu_stream_ctrl.sv
// Bench for alu_stream_ctrl: directed vectors plus random
// commands against an arithmetic reference model.
module tb_alu_stream_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sweep = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_f = '0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_valid, out_last;
  logic [W-1:0] out_y;
  logic [2:0]   out_t, out_f;
  logic [7:0]   res_cnt;

  logic         w_in_ready, w_out_valid, w_out_last;
  logic [W-1:0] w_out_y;
  logic [2:0]   w_out_t, w_out_f;
  logic [1:0]   w_res_cnt;

  int pass_cnt = 0;
  int tot_cnt = 0;
  int model_cnt = 0;

  alu_stream_ctrl #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sweep(in_sweep), .in_a(in_a), .in_b(in_b), .in_f(in_f),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_t(out_t), .out_f(out_f),
    .out_last(out_last), .res_cnt(res_cnt)
  );

  alu_stream_ctrl #(.WIDTH(W), .CNT_W(2)) dut_w (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_sweep(in_sweep), .in_a(in_a), .in_b(in_b), .in_f(in_f),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_y(w_out_y), .out_t(w_out_t), .out_f(w_out_f),
    .out_last(w_out_last), .res_cnt(w_res_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_y(input int a, input int b, input int f);
    int m, s, sa, r;
    m  = 1 << W;
    s  = b % W;
    sa = (a >= m / 2) ? a - m : a;
    case (f)
      0:       r = a - b;
      1:       r = a + b;
      2:       r = a & b;
      3:       r = a | b;
      4:       r = a ^ b;
      5:       r = a >> s;
      6:       r = a << s;
      default: r = sa >>> s;
    endcase
    r = ((r % m) + m) % m;
    return W'(r);
  endfunction

  function automatic logic [2:0] ref_t(input int a, input int b);
    int m, sa, sb;
    m  = 1 << W;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    return {a < b, sa < sb, a == b};
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_cnt = 0;
  endtask

  // One command end to end; stall < 0 picks random backpressure.
  task automatic do_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f, input logic sw, input int stall);
    int n, st, wc;
    logic [W-1:0] ey;
    logic [2:0]   et, ef;
    logic         el;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_f = f;
    in_sweep = sw;
    wc = 0;
    while (!in_ready && wc < 10) begin
      @(negedge clk);
      wc++;
    end
    if (!in_ready) begin
      tot_cnt++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_f = 3'($urandom);
    in_sweep = ~sw;
    n = sw ? 8 : 1;
    for (int k = 0; k < n; k++) begin
      ef = sw ? k[2:0] : f;
      ey = ref_y(int'(a), int'(b), int'(ef));
      et = ref_t(int'(a), int'(b));
      el = (k == n - 1);
      tot_cnt++;
      if ({out_valid, in_ready} !== 2'b00) begin
        $display("FAIL exec_state valid,ready=%b required 00", {out_valid, in_ready});
      end else pass_cnt++;
      out_ready = 1'($urandom);
      @(negedge clk);
      out_ready = 1'b0;
      tot_cnt++;
      if ({out_valid, out_y, out_t, out_f, out_last} !== {1'b1, ey, et, ef, el}) begin
        $display("FAIL result v,y,t,f,last=%b required %b",
                 {out_valid, out_y, out_t, out_f, out_last}, {1'b1, ey, et, ef, el});
      end else pass_cnt++;
      st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      repeat (st) begin
        in_a = W'($urandom);
        @(negedge clk);
        tot_cnt++;
        if ({out_valid, in_ready, out_y, out_t, out_f, out_last} !==
            {2'b10, ey, et, ef, el}) begin
          $display("FAIL hold v,rdy,y,t,f,last=%b required %b",
                   {out_valid, in_ready, out_y, out_t, out_f, out_last},
                   {2'b10, ey, et, ef, el});
        end else pass_cnt++;
      end
      if (k == n - 1) in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      model_cnt++;
      tot_cnt++;
      if ({out_valid, out_y, out_t, out_f, out_last, res_cnt, w_res_cnt} !==
          {1'b0, ey, et, ef, el, model_cnt[7:0], model_cnt[1:0]}) begin
        $display("FAIL handshake v,y,t,f,last,cnt,wcnt=%b required %b",
                 {out_valid, out_y, out_t, out_f, out_last, res_cnt, w_res_cnt},
                 {1'b0, ey, et, ef, el, model_cnt[7:0], model_cnt[1:0]});
      end else pass_cnt++;
      if (k == n - 1) begin
        tot_cnt++;
        if (in_ready !== 1'b1) begin
          $display("FAIL back_to_idle in_ready=%b required 1", in_ready);
        end else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tot_cnt++;
    if ({out_valid, out_y, out_t, out_f, out_last, res_cnt, w_res_cnt, in_ready} !==
        {1'b0, 4'h0, 3'h0, 3'h0, 1'b0, 8'h0, 2'h0, 1'b1}) begin
      $display("FAIL reset_vals got %b",
               {out_valid, out_y, out_t, out_f, out_last, res_cnt, w_res_cnt, in_ready});
    end else pass_cnt++;
    rstn = 1'b1;
    @(negedge clk);
    tot_cnt++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL reset_release rdy,valid=%b required 10", {in_ready, out_valid});
    end else pass_cnt++;
  endtask

  task automatic test_single_op();
    do_cmd(4'b1011, 4'b1100, 3'b001, 1'b0, 0);
  endtask

  task automatic test_sweep();
    do_cmd(4'b1011, 4'b0001, 3'b101, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    do_cmd(4'b0101, 4'b0011, 3'b100, 1'b0, 5);
    do_cmd(4'b1001, 4'b0010, 3'b000, 1'b1, 2);
  endtask

  task automatic test_compare();
    do_cmd(4'b0110, 4'b0110, 3'b000, 1'b0, 0);
    do_cmd(4'b0010, 4'b1110, 3'b010, 1'b0, 1);
  endtask

  task automatic test_reset_mid_sweep();
    int wc;
    @(negedge clk);
    in_valid = 1'b1;
    in_sweep = 1'b1;
    in_a = 4'b1011;
    in_b = 4'b0001;
    wc = 0;
    while (!in_ready && wc < 10) begin
      @(negedge clk);
      wc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wc = 0;
    while (!(out_valid && out_f == 3'b011) && wc < 40) begin
      @(negedge clk);
      wc++;
    end
    out_ready = 1'b0;
    tot_cnt++;
    if (!(out_valid && out_f == 3'b011)) begin
      $display("FAIL sweep_reach_f3 valid=%b f=%b required 1,011", out_valid, out_f);
    end else pass_cnt++;
    rstn = 1'b0;
    #1;
    tot_cnt++;
    if ({out_valid, out_y, out_t, out_f, out_last, res_cnt, w_res_cnt, in_ready} !==
        {1'b0, 4'h0, 3'h0, 3'h0, 1'b0, 8'h0, 2'h0, 1'b1}) begin
      $display("FAIL async_reset got %b",
               {out_valid, out_y, out_t, out_f, out_last, res_cnt, w_res_cnt, in_ready});
    end else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    model_cnt = 0;
    @(negedge clk);
    tot_cnt++;
    if ({in_ready, out_valid, res_cnt} !== {2'b10, 8'h0}) begin
      $display("FAIL after_reset rdy,valid,cnt=%b required 10_00000000",
               {in_ready, out_valid, res_cnt});
    end else pass_cnt++;
    do_cmd(4'b0111, 4'b0001, 3'b110, 1'b0, 0);
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w [5];
    exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      do_cmd(W'($urandom), W'($urandom), 3'($urandom), 1'b0, 0);
      tot_cnt++;
      if (w_res_cnt !== exp_w[i]) begin
        $display("FAIL wrap_%0d res_cnt=%0d required %0d", i, w_res_cnt, exp_w[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_cmd(W'($urandom), W'($urandom), 3'($urandom),
             ($urandom_range(0, 3) == 0), -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_sweep();
    test_backpressure();
    test_compare();
    test_reset_mid_sweep();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
